// File: rtl/vdc_video_gen.sv
// Stand-in VDC pixel/sync source: programmable raster timing at the three PCE
// dot-clock rates with a test pattern in the active area and border colour outside.
module vdc_video_gen #(
    parameter int H_DISP   = 256,
    parameter int H_TOTAL  = 341,
    parameter int HS_START = 288,
    parameter int HS_LEN   = 24,
    parameter int V_DISP   = 240,
    parameter int V_TOTAL  = 262,
    parameter int VS_START = 246,
    parameter int VS_LEN   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [1:0] pattern,
    input  logic [8:0] solid_idx,
    output logic [8:0] VD,
    output logic       HSYN,
    output logic       VSYN,
    output logic       pix_en,
    output logic       frame_start
);

    // All raster comparisons are 10 bits wide so START+LEN never wraps.
    localparam logic [9:0] H_DISP_W  = 10'(H_DISP);
    localparam logic [9:0] H_LAST_W  = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_LO_W   = 10'(HS_START);
    localparam logic [9:0] HS_HI_W   = 10'(HS_START + HS_LEN);
    localparam logic [9:0] V_DISP_W  = 10'(V_DISP);
    localparam logic [9:0] V_LAST_W  = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_LO_W   = 10'(VS_START);
    localparam logic [9:0] VS_HI_W   = 10'(VS_START + VS_LEN);
    localparam logic [8:0] BORDER_IDX = 9'h100;

    logic [2:0] div_cnt;
    logic [8:0] h_cnt;
    logic [8:0] v_cnt;
    logic [1:0] mode_q;
    logic [1:0] pattern_q;

    logic [9:0] h_w;
    logic [9:0] v_w;
    logic       tick;
    logic       h_wrap;
    logic       v_wrap;
    logic       active;
    logic       hs_act;
    logic       vs_act;
    logic       at_origin;
    logic [8:0] vd_next;

    function automatic logic [2:0] div_last(input logic [1:0] m);
        case (m)
            2'b00:   return 3'd7;
            2'b01:   return 3'd5;
            default: return 3'd3;
        endcase
    endfunction

    assign h_w       = {1'b0, h_cnt};
    assign v_w       = {1'b0, v_cnt};
    assign tick      = (div_cnt == div_last(mode_q));
    assign h_wrap    = (h_w == H_LAST_W);
    assign v_wrap    = (v_w == V_LAST_W);
    assign active    = (h_w < H_DISP_W) && (v_w < V_DISP_W);
    assign hs_act    = (h_w >= HS_LO_W) && (h_w < HS_HI_W);
    assign vs_act    = (v_w >= VS_LO_W) && (v_w < VS_HI_W);
    assign at_origin = (h_cnt == 9'd0) && (v_cnt == 9'd0);

    always_comb begin
        vd_next = BORDER_IDX;
        if (active) begin
            case (pattern_q)
                2'd0:    vd_next = solid_idx;
                2'd1:    vd_next = {6'd0, h_cnt[7:5]};
                2'd2:    vd_next = (h_cnt[3] ^ v_cnt[3]) ? 9'h00F : 9'h000;
                default: vd_next = {v_cnt[0], h_cnt[7:0]};
            endcase
        end
    end

    // Stage boundary: outputs register the pre-tick counter position.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt     <= 3'd0;
            h_cnt       <= 9'd0;
            v_cnt       <= 9'd0;
            mode_q      <= mode;
            pattern_q   <= pattern;
            VD          <= BORDER_IDX;
            HSYN        <= 1'b1;
            VSYN        <= 1'b1;
            pix_en      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= tick;
            frame_start <= tick && at_origin;
            if (tick) begin
                div_cnt <= 3'd0;
                VD      <= vd_next;
                HSYN    <= ~hs_act;
                VSYN    <= ~vs_act;
                if (h_wrap) begin
                    h_cnt <= 9'd0;
                    if (v_wrap) begin
                        v_cnt     <= 9'd0;
                        // Mode/pattern only change on the frame boundary.
                        mode_q    <= mode;
                        pattern_q <= pattern;
                    end else begin
                        v_cnt <= v_cnt + 9'd1;
                    end
                end else begin
                    h_cnt <= h_cnt + 9'd1;
                end
            end else begin
                div_cnt <= div_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_vdc_video_gen.sv
// Bench for vdc_video_gen: linear-position raster model checked every clock,
// plus literal expectations at known raster coordinates.
module tb_vdc_video_gen;

    localparam int H_DISP   = 256;
    localparam int H_TOTAL  = 341;
    localparam int HS_START = 288;
    localparam int HS_LEN   = 24;
    localparam int V_DISP   = 9;
    localparam int V_TOTAL  = 13;
    localparam int VS_START = 10;
    localparam int VS_LEN   = 2;
    localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd2;
    logic [1:0] pattern = 2'd1;
    logic [8:0] solid_idx = 9'd0;
    logic [8:0] VD;
    logic       HSYN;
    logic       VSYN;
    logic       pix_en;
    logic       frame_start;

    vdc_video_gen #(
        .H_DISP(H_DISP), .H_TOTAL(H_TOTAL), .HS_START(HS_START), .HS_LEN(HS_LEN),
        .V_DISP(V_DISP), .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_LEN(VS_LEN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mode(mode),
        .pattern(pattern),
        .solid_idx(solid_idx),
        .VD(VD),
        .HSYN(HSYN),
        .VSYN(VSYN),
        .pix_en(pix_en),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_tot  = 0;
    int phase  = 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    endtask

    function automatic int div_of(input logic [1:0] m);
        if (m == 2'd0) return 8;
        if (m == 2'd1) return 6;
        return 4;
    endfunction

    function automatic logic [8:0] pix_of(input int x, input int y, input int pat, input logic [8:0] solid);
        if (x >= H_DISP || y >= V_DISP) return 9'h100;
        case (pat)
            0:       return solid;
            1:       return 9'(x / 32);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 9'h00F : 9'h000;
            default: return 9'((y % 2) * 256 + (x % 256));
        endcase
    endfunction

    // Behavioural model: a clock count within the pixel period and a linear
    // position within the frame.
    int         m_cnt = 0;
    int         m_pos = 0;
    int         m_div = 4;
    int         m_pat = 1;
    int         mx = 0;
    int         my = 0;
    bit         m_rst = 1'b1;
    logic [8:0] e_vd = 9'h100;
    logic       e_hs = 1'b1;
    logic       e_vs = 1'b1;
    logic       e_pe = 1'b0;
    logic       e_fs = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_rst = 1'b1;
            m_cnt = 0;
            m_pos = 0;
            m_div = div_of(mode);
            m_pat = int'(pattern);
            e_vd = 9'h100; e_hs = 1'b1; e_vs = 1'b1; e_pe = 1'b0; e_fs = 1'b0;
        end else begin
            m_rst = 1'b0;
            m_cnt++;
            e_pe = 1'b0;
            e_fs = 1'b0;
            if (m_cnt == m_div) begin
                m_cnt = 0;
                mx = m_pos % H_TOTAL;
                my = m_pos / H_TOTAL;
                e_vd = pix_of(mx, my, m_pat, solid_idx);
                e_hs = !(mx >= HS_START && mx < HS_START + HS_LEN);
                e_vs = !(my >= VS_START && my < VS_START + VS_LEN);
                e_pe = 1'b1;
                e_fs = (m_pos == 0);
                m_pos = (m_pos + 1) % FRAME_TICKS;
                if (m_pos == 0) begin
                    m_div = div_of(mode);
                    m_pat = int'(pattern);
                end
            end
        end
    end

    int cyc = 0;
    int last_pe = 0;
    int pe_seen = 0;
    int fs_seen = 0;
    int last_fs_tick = 0;
    int hs_low = 0;

    always @(negedge clock) begin
        int exp_gap;
        cyc++;
        chk("VD", int'(VD), int'(e_vd));
        chk("HSYN", int'(HSYN), int'(e_hs));
        chk("VSYN", int'(VSYN), int'(e_vs));
        chk("pix_en", int'(pix_en), int'(e_pe));
        chk("frame_start", int'(frame_start), int'(e_fs));
        if (m_rst) begin
            chk("rst_VD", int'(VD), 'h100);
            chk("rst_HSYN", int'(HSYN), 1);
            chk("rst_VSYN", int'(VSYN), 1);
            chk("rst_pix_en", int'(pix_en), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            pe_seen = 0;
            fs_seen = 0;
            hs_low = 0;
        end else begin
            if (HSYN == 1'b0) hs_low++;
            else begin
                if (hs_low > 0 && phase < 3) chk("hsyn_low_clocks", hs_low, 96);
                hs_low = 0;
            end
            if (pix_en) begin
                pe_seen++;
                if (frame_start) fs_seen++;
                if (pe_seen == 1) chk("first_tick_frame_start", int'(frame_start), 1);
                else begin
                    if (phase < 3) exp_gap = 4;
                    else if (frame_start) exp_gap = 6;
                    else exp_gap = (fs_seen <= 1) ? 8 : 6;
                    chk("tick_gap", cyc - last_pe, exp_gap);
                end
                if (frame_start && fs_seen > 1) chk("frame_ticks", pe_seen - last_fs_tick, FRAME_TICKS);
                if (frame_start) last_fs_tick = pe_seen;
                last_pe = cyc;
            end
            if (e_pe) begin
                if (m_pat == 1 && my == 0) begin
                    if (mx == 0)   chk("bar_x0", int'(VD), 0);
                    if (mx == 31)  chk("bar_x31", int'(VD), 0);
                    if (mx == 224) chk("bar_x224", int'(VD), 7);
                    if (mx == 256) chk("bar_x256", int'(VD), 'h100);
                end
                if (m_pat == 1 && my == 3 && mx == 255) chk("bar_x255_y3", int'(VD), 7);
                if (m_pat == 3) begin
                    if (mx == 5 && my == 0)   chk("ramp_5_0", int'(VD), 'h005);
                    if (mx == 5 && my == 1)   chk("ramp_5_1", int'(VD), 'h105);
                    if (mx == 5 && my == 9)   chk("ramp_5_9", int'(VD), 'h100);
                    if (mx == 200 && my == 9) chk("ramp_200_9", int'(VD), 'h100);
                end
                if (m_pat == 2) begin
                    if (mx == 0 && my == 0) chk("chk_0_0", int'(VD), 'h000);
                    if (mx == 8 && my == 0) chk("chk_8_0", int'(VD), 'h00F);
                    if (mx == 8 && my == 8) chk("chk_8_8", int'(VD), 'h000);
                    if (mx == 0 && my == 8) chk("chk_0_8", int'(VD), 'h00F);
                end
                if (mx == 340 && my == 9)  chk("vsyn_before", int'(VSYN), 1);
                if (mx == 0 && my == 10)   chk("vsyn_fall", int'(VSYN), 0);
                if (mx == 340 && my == 11) chk("vsyn_last", int'(VSYN), 0);
                if (mx == 0 && my == 12)   chk("vsyn_rise", int'(VSYN), 1);
                if (mx == 288 && my == 10) chk("hsyn_in_vsync", int'(HSYN), 0);
                if (mx == 311 && my == 11) chk("hsyn_end_in_vsync", int'(HSYN), 0);
                if (mx == 312 && my == 10) chk("hsyn_off_in_vsync", int'(HSYN), 1);
            end
        end
    end

    initial begin
        // Divide by 4, bars; mode/pattern scrambled mid-frame then restored.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2000 * 4) begin
            @(negedge clock);
            solid_idx = 9'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                mode = 2'($urandom);
                pattern = 2'($urandom);
            end
        end
        mode = 2'd2;
        pattern = 2'd1;
        repeat ((FRAME_TICKS - 2000 + 5 * H_TOTAL + 100) * 4) @(negedge clock);

        // One-clock reset mid-line 5; restart at divide by 4 with solid pattern.
        phase = 2;
        reset = 1'b1;
        mode = 2'd3;
        pattern = 2'd0;
        @(negedge clock);
        reset = 1'b0;
        repeat (1000 * 4) begin
            @(negedge clock);
            solid_idx = 9'($urandom);
        end

        // Divide by 8 with ramp, then a mid-frame switch to divide by 6 / checker.
        reset = 1'b1;
        mode = 2'd0;
        pattern = 2'd3;
        @(negedge clock);
        phase = 3;
        @(negedge clock);
        reset = 1'b0;
        repeat (1000 * 8) @(negedge clock);
        mode = 2'd1;
        pattern = 2'd2;
        repeat (500 * 8) begin
            @(negedge clock);
            solid_idx = 9'($urandom);
        end
        repeat ((FRAME_TICKS - 1500) * 8 + 10 * H_TOTAL * 6) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
